rf_scoreboard_mp: RTL

Parametrised, clocked successor to the 8×16 register file: DEPTH×DATA_W storage, two asynchronous read ports, one synchronous write port, write-to-read bypass, optional hardwired zero register, and a per-register pending scoreboard. The decode stage reads operands and reserves destinations through it. The writeback stage writes results and releases reservations. The `hazard` output drives the pipeline stall logic.

---
 rtl/rf_pkg.sv | 20 ++
 rtl/rf_pend_table.sv | 33 +++
 rtl/rf_scoreboard_mp.sv | 71 +++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared defaults, typedefs and register index names for the
// scoreboarded register file.
package rf_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 3;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  localparam rf_addr_t V0 = 3'd0;
  localparam rf_addr_t V1 = 3'd1;
  localparam rf_addr_t V2 = 3'd2;
  localparam rf_addr_t V3 = 3'd3;
  localparam rf_addr_t V4 = 3'd4;
  localparam rf_addr_t V5 = 3'd5;
  localparam rf_addr_t A0 = 3'd6;
  localparam rf_addr_t A1 = 3'd7;

endpackage

// File: rtl/rf_pend_table.sv
// Per-register pending bits: flush clears all, a write releases its
// destination, and an issue reserves its destination last so it wins.
module rf_pend_table
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wrEn,
  input  logic [ADDR_W-1:0]     wrAddr,
  input  logic                  issueEn,
  input  logic [ADDR_W-1:0]     issueAddr,
  input  logic                  flush,
  output logic [2**ADDR_W-1:0]  pend
);

  logic [2**ADDR_W-1:0] pendNext;

  always_comb begin
    pendNext = flush ? '0 : pend;
    if (wrEn)          pendNext[wrAddr]    = 1'b0;
    if (issueEn)       pendNext[issueAddr] = 1'b1;
    if (ZERO_REG != 0) pendNext[0]         = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend <= '0;
    else        pend <= pendNext;
  end

endmodule

// File: rtl/rf_scoreboard_mp.sv
// Parametrised register file with two async read ports, write-to-read
// bypass, optional hardwired zero register and a pending scoreboard.
module rf_scoreboard_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              busy1,
  output logic              busy2,
  output logic              hazard,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              flush
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic              wrStore;
  logic              isZero1, isZero2, fwd1, fwd2;

  assign wrStore = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wrStore) begin
      regs[wr_addr] <= wr_data;
    end
  end

  rf_pend_table #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) pendTable (
    .clk       (clk),
    .reset     (reset),
    .wrEn      (wr_en),
    .wrAddr    (wr_addr),
    .issueEn   (issue_en),
    .issueAddr (issue_addr),
    .flush     (flush),
    .pend      (pend)
  );

  // Forwarding also applies while reset is low; the write just isn't stored.
  assign isZero1 = (ZERO_REG != 0) && (rd_addr1 == '0);
  assign isZero2 = (ZERO_REG != 0) && (rd_addr2 == '0);
  assign fwd1    = (BYPASS != 0) && wr_en && (wr_addr == rd_addr1);
  assign fwd2    = (BYPASS != 0) && wr_en && (wr_addr == rd_addr2);

  assign rd_data1 = isZero1 ? '0 : (fwd1 ? wr_data : regs[rd_addr1]);
  assign rd_data2 = isZero2 ? '0 : (fwd2 ? wr_data : regs[rd_addr2]);
  assign busy1    = !isZero1 && !fwd1 && pend[rd_addr1];
  assign busy2    = !isZero2 && !fwd2 && pend[rd_addr2];
  assign hazard   = busy1 | busy2;

endmodule
